// File: rtl/lz77_match_finder.sv
// LZ77 longest-match search engine. Latches a search window and a lookahead
// window on start, then walks every candidate start position, issuing one
// byte-equality subtract to an external ALU per cycle and using its zero flag.
// Reports the longest match as (offset, length, next_char).
module lz77_match_finder #(
  parameter int SEARCH_LEN = 8,
  parameter int LOOK_LEN   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [8*SEARCH_LEN-1:0]       search_buf,
  input  logic [8*LOOK_LEN-1:0]         look_buf,
  output logic                          busy,
  output logic                          valid,
  output logic [$clog2(LOOK_LEN)-1:0]   match_len,
  output logic [$clog2(SEARCH_LEN):0]   match_offset,
  output logic [7:0]                    next_char,
  output logic [7:0]                    alu_src1,
  output logic [7:0]                    alu_src2,
  output logic                          alu_ainvert,
  output logic                          alu_binvert,
  output logic [1:0]                    alu_op,
  input  logic                          alu_zero
);
  localparam int IW = $clog2(SEARCH_LEN);
  localparam int LW = $clog2(LOOK_LEN);
  localparam int OW = IW + 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t                         state;
  logic [SEARCH_LEN-1:0][7:0]     s_mem;
  logic [LOOK_LEN-1:0][7:0]       l_mem;
  logic [IW-1:0]                  i_q, best_i_q;
  logic [LW-1:0]                  j_q, best_len_q;

  // per-cycle decision derived from the ALU zero flag
  int            lim, run;
  logic          step, better, finish;
  logic [LW-1:0] nlen;
  logic [IW-1:0] ni;
  logic [IW-1:0] sidx;

  // Run bookkeeping: extend the current run or close it and update the best.
  always_comb begin
    lim    = (LOOK_LEN - 1 < SEARCH_LEN - int'(i_q)) ? LOOK_LEN - 1
                                                     : SEARCH_LEN - int'(i_q);
    step   = alu_zero && (int'(j_q) + 1 < lim);
    run    = alu_zero ? int'(j_q) + 1 : int'(j_q);
    better = run > int'(best_len_q);
    nlen   = better ? LW'(run) : best_len_q;
    ni     = better ? i_q : best_i_q;
    // a closed run ends the search at the last position or on a full-length hit
    finish = !step && ((int'(i_q) == SEARCH_LEN - 1) || (int'(nlen) == LOOK_LEN - 1));
    sidx   = i_q + IW'(j_q);
  end

  // ALU drive: subtract S[i+j] - L[j] while comparing, quiet otherwise.
  always_comb begin
    alu_src1    = 8'h00;
    alu_src2    = 8'h00;
    alu_ainvert = 1'b0;
    alu_binvert = 1'b0;
    alu_op      = 2'b00;
    if (state == COMPARE) begin
      alu_src1    = s_mem[sidx];
      alu_src2    = l_mem[j_q];
      alu_binvert = 1'b1;
      alu_op      = 2'b10;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_mem        <= '0;
      l_mem        <= '0;
      i_q          <= '0;
      j_q          <= '0;
      best_i_q     <= '0;
      best_len_q   <= '0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      match_len    <= '0;
      match_offset <= '0;
      next_char    <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            s_mem      <= search_buf;
            l_mem      <= look_buf;
            i_q        <= '0;
            j_q        <= '0;
            best_i_q   <= '0;
            best_len_q <= '0;
            busy       <= 1'b1;
            state      <= COMPARE;
          end
        end
        COMPARE: begin
          if (step) begin
            j_q <= j_q + 1'b1;
          end else begin
            best_len_q <= nlen;
            best_i_q   <= ni;
            i_q        <= i_q + 1'b1;
            j_q        <= '0;
            if (finish) begin
              busy         <= 1'b0;
              valid        <= 1'b1;
              match_len    <= nlen;
              match_offset <= (nlen == '0) ? '0 : OW'(SEARCH_LEN) - OW'(ni);
              next_char    <= l_mem[nlen];
              state        <= DONE;
            end
          end
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lz77_match_finder.sv
// Scoreboard bench for lz77_match_finder with a behavioural ALU and a
// reference model that scores every start position directly.
module tb_lz77_match_finder;
  localparam int SL = 8;
  localparam int LL = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [8*SL-1:0] search_buf;
  logic [8*LL-1:0] look_buf;
  logic            busy, valid;
  logic [1:0]      match_len;
  logic [3:0]      match_offset;
  logic [7:0]      next_char;
  logic [7:0]      alu_src1, alu_src2;
  logic            alu_ainvert, alu_binvert;
  logic [1:0]      alu_op;
  logic            alu_zero;

  lz77_match_finder #(.SEARCH_LEN(SL), .LOOK_LEN(LL)) dut (
    .clk(clk), .reset(reset), .start(start),
    .search_buf(search_buf), .look_buf(look_buf),
    .busy(busy), .valid(valid),
    .match_len(match_len), .match_offset(match_offset), .next_char(next_char),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ainvert(alu_ainvert), .alu_binvert(alu_binvert),
    .alu_op(alu_op), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // 8-bit ALU: AND / OR / ADD (binvert doubles as carry-in) / SLT
  logic [7:0] aa, bb, sum, res;
  always_comb begin
    aa  = alu_ainvert ? ~alu_src1 : alu_src1;
    bb  = alu_binvert ? ~alu_src2 : alu_src2;
    sum = aa + bb + {7'd0, alu_binvert};
    case (alu_op)
      2'b00:   res = aa & bb;
      2'b01:   res = aa | bb;
      2'b10:   res = sum;
      default: res = {7'd0, sum[7]};
    endcase
    alu_zero = (res == 8'h00);
  end

  typedef struct {
    int len;
    int off;
    int nc;
    int n;
    int c0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: score each start position, keep the first strictly longer run.
  task automatic model(input logic [8*SL-1:0] s, input logic [8*LL-1:0] l, output exp_t e);
    int best, bi, n;
    best = 0; bi = 0; n = 0;
    for (int i = 0; i < SL; i++) begin
      int lim, run;
      lim = (LL - 1 < SL - i) ? LL - 1 : SL - i;
      run = 0;
      while (run < lim && s[8*(i+run) +: 8] == l[8*run +: 8]) run++;
      n += (run + 1 < lim) ? run + 1 : lim;
      if (run > best) begin best = run; bi = i; end
      if (best == LL - 1) break;
    end
    e.len = best;
    e.off = (best == 0) ? 0 : SL - bi;
    e.nc  = int'(l[8*best +: 8]);
    e.n   = n;
    e.c0  = 0;
  endtask

  // Monitor: count compare cycles, and score every valid against the queue.
  initial begin
    int ccnt;
    exp_t e;
    ccnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy) begin
          if (alu_op == 2'b10 && alu_binvert && !alu_ainvert) ccnt++;
        end else if (!valid) ccnt = 0;
        if (valid) begin
          vcnt++;
          if (sb.size() == 0) check("spurious_valid", 1, 0);
          else begin
            e = sb.pop_front();
            check("len", int'(match_len), e.len);
            check("offset", int'(match_offset), e.off);
            check("next_char", int'(next_char), e.nc);
            check("latency", cyc - e.c0, e.n + 1);
            check("compares", ccnt, e.n);
            check("busy_at_valid", int'(busy), 0);
            check("alu_idle", int'({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op}), 0);
          end
          ccnt = 0;
        end
      end
    end
  end

  task automatic do_start(input logic [8*SL-1:0] s, input logic [8*LL-1:0] l, input bit push);
    exp_t e;
    model(s, l, e);
    e.c0 = cyc;
    search_buf = s;
    look_buf   = l;
    start      = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    search_buf = {$urandom(), $urandom()};
    look_buf   = $urandom();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_result"}, int'({match_len, match_offset, next_char}), 0);
    check({tag, "_alu"}, int'({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op}), 0);
  endtask

  initial begin
    logic [8*SL-1:0] s;
    logic [8*LL-1:0] l;
    int v0;
    reset = 1'b1; start = 1'b0; search_buf = '0; look_buf = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // full match with early termination
    do_start(64'h07060504_03020100, 32'h7F050403, 1'b1); wait_idle();
    // no match
    do_start(64'h07060504_03020100, 32'hAAAAAAAA, 1'b1); wait_idle();
    // tie-break keeps the oldest position
    do_start(64'h00004241_00004241, 32'h99994241, 1'b1); wait_idle();
    // match running into the end of the window
    do_start(64'h55550000_00000000, 32'h00555555, 1'b1); wait_idle();

    // randomized windows over a small alphabet so matches are frequent
    for (int k = 0; k < 40; k++) begin
      for (int b = 0; b < SL; b++) s[8*b +: 8] = 8'($urandom_range(0, 2));
      for (int b = 0; b < LL; b++) l[8*b +: 8] = 8'($urandom_range(0, 2));
      do_start(s, l, 1'b1);
      wait_idle();
    end

    // give the result registers a nonzero value, then abort a search by reset
    do_start(64'h07060504_03020100, 32'h7F050403, 1'b1); wait_idle();
    do_start(64'h07060504_03020100, 32'hAAAAAAAA, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("abort");
    v0 = vcnt;
    repeat (20) @(negedge clk);
    check("abort_no_valid", vcnt - v0, 0);

    // start while busy is ignored
    v0 = vcnt;
    do_start(64'h00004241_00004241, 32'h99994241, 1'b1);
    @(negedge clk);
    do_start(64'h07060504_03020100, 32'h7F050403, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk);
    check("overlap_valids", vcnt - v0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
